// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8-bit LSB-first UART transmitter with optional parity and 1/2 stop bits
//   clk             system clock
//   rst             synchronous active-low reset
//   transmit        send request, sampled only while idle
//   tx_byte         byte captured on the accepting edge
//   tx              serial line, idle high
//   is_transmitting high from the accepting edge through the last stop bit
//   tx_done         one-cycle pulse on the edge a frame completes
module uart_tx_serializer #(
   parameter int CLKS_PER_BIT = 868,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       transmit,
   input  logic [7:0] tx_byte,
   output logic       tx,
   output logic       is_transmitting,
   output logic       tx_done
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
   state_t        state;
   logic [CW-1:0] baud;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic          par;
   always_ff @(posedge clk) begin
      if (!rst) begin
         state           <= S_IDLE;
         baud            <= '0;
         bit_idx         <= '0;
         shift           <= '0;
         par             <= 1'b0;
         tx              <= 1'b1;
         is_transmitting <= 1'b0;
         tx_done         <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         if (state == S_IDLE) begin
            tx              <= 1'b1;
            is_transmitting <= 1'b0;
            if (transmit) begin
               shift           <= tx_byte;
               par             <= (PARITY == 1) ? ~^tx_byte : ^tx_byte;
               tx              <= 1'b0;
               is_transmitting <= 1'b1;
               baud            <= '0;
               state           <= S_START;
            end
         end else if (baud != LAST) begin
            baud <= baud + CW'(1);
         end else begin
            // terminal count: the next bit goes out on this same edge
            baud <= '0;
            case (state)
               S_START: begin
                  tx      <= shift[0];
                  bit_idx <= '0;
                  state   <= S_DATA;
               end
               S_DATA: begin
                  if (bit_idx == 3'd7) begin
                     bit_idx <= '0;
                     tx      <= (PARITY != 0) ? par : 1'b1;
                     state   <= (PARITY != 0) ? S_PARITY : S_STOP;
                  end else begin
                     shift   <= shift >> 1;
                     tx      <= shift[1];
                     bit_idx <= bit_idx + 3'd1;
                  end
               end
               S_PARITY: begin
                  tx      <= 1'b1;
                  bit_idx <= '0;
                  state   <= S_STOP;
               end
               S_STOP: begin
                  // bit_idx counts stop-bit periods
                  if (bit_idx == 3'(STOP_BITS - 1)) begin
                     bit_idx         <= '0;
                     is_transmitting <= 1'b0;
                     tx_done         <= 1'b1;
                     state           <= S_IDLE;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed self-checking bench over four parameter sets
module tb_uart_tx_serializer;
   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] trans;
   logic [7:0] tx_byte;
   logic [3:0] tx_w, busy, done;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) d0 (
      .clk(clk), .rst(rst), .transmit(trans[0]), .tx_byte(tx_byte),
      .tx(tx_w[0]), .is_transmitting(busy[0]), .tx_done(done[0]));
   uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) d1 (
      .clk(clk), .rst(rst), .transmit(trans[1]), .tx_byte(tx_byte),
      .tx(tx_w[1]), .is_transmitting(busy[1]), .tx_done(done[1]));
   uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) d2 (
      .clk(clk), .rst(rst), .transmit(trans[2]), .tx_byte(tx_byte),
      .tx(tx_w[2]), .is_transmitting(busy[2]), .tx_done(done[2]));
   uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(2)) d3 (
      .clk(clk), .rst(rst), .transmit(trans[3]), .tx_byte(tx_byte),
      .tx(tx_w[3]), .is_transmitting(busy[3]), .tx_done(done[3]));

   // Sends b on instance i and checks every cycle of the frame against the slot list
   // (start, data LSB first, parity bit, stop bits). Optionally pulses transmit with
   // 0x3C at frame cycle pulse_at to check busy requests are ignored.
   task automatic run_frame(input int i, input logic [7:0] b, input int p, input int s,
                            input int pulse_at, input string nm);
      logic exp[$];
      exp.push_back(1'b0);
      for (int j = 0; j < 8; j++) exp.push_back(b[j]);
      if (p == 1) exp.push_back(~^b);
      if (p == 2) exp.push_back(^b);
      for (int j = 0; j < s; j++) exp.push_back(1'b1);
      tx_byte  = b;
      trans[i] = 1'b1;
      @(negedge clk);
      trans[i] = 1'b0;
      for (int c = 0; c < exp.size() * 4; c++) begin
         if (c == pulse_at) begin
            trans[i] = 1'b1;
            tx_byte  = 8'h3C;
         end else if (c == pulse_at + 1) begin
            trans[i] = 1'b0;
         end
         checks++;
         if (tx_w[i] !== exp[c/4] || busy[i] !== 1'b1 || done[i] !== 1'b0) begin
            errors++;
            $display("FAIL %s cycle %0d: tx=%b busy=%b done=%b, want tx=%b busy=1 done=0",
                     nm, c, tx_w[i], busy[i], done[i], exp[c/4]);
         end
         @(negedge clk);
      end
      checks++;
      if (tx_w[i] !== 1'b1 || busy[i] !== 1'b0 || done[i] !== 1'b1) begin
         errors++;
         $display("FAIL %s end: tx=%b busy=%b done=%b, want tx=1 busy=0 done=1",
                  nm, tx_w[i], busy[i], done[i]);
      end
      @(negedge clk);
      checks++;
      if (done[i] !== 1'b0) begin
         errors++;
         $display("FAIL %s done_width: done=%b, want 0", nm, done[i]);
      end
   endtask

   task automatic test_reset();
      rst     = 1'b0;
      trans   = 4'b0;
      tx_byte = 8'h00;
      repeat (3) @(negedge clk);
      checks++;
      if (tx_w !== 4'hF || busy !== 4'h0 || done !== 4'h0) begin
         errors++;
         $display("FAIL reset: tx=%b busy=%b done=%b, want tx=1111 busy=0000 done=0000",
                  tx_w, busy, done);
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (tx_w !== 4'hF || busy !== 4'h0) begin
         errors++;
         $display("FAIL post_reset_idle: tx=%b busy=%b, want tx=1111 busy=0000", tx_w, busy);
      end
   endtask

   task automatic test_basic();
      run_frame(0, 8'hA5, 0, 1, -1, "basic_a5");
      run_frame(0, 8'h00, 0, 1, -1, "basic_00");
   endtask

   task automatic test_parity();
      run_frame(1, 8'h07, 2, 1, -1, "even_07");
      run_frame(2, 8'h07, 1, 1, -1, "odd_07");
      run_frame(1, 8'hC3, 2, 1, -1, "even_c3");
      run_frame(2, 8'hC3, 1, 1, -1, "odd_c3");
   endtask

   task automatic test_stop2();
      run_frame(3, 8'hFF, 0, 2, -1, "stop2_ff");
   endtask

   task automatic test_busy_ignored();
      int late;
      run_frame(0, 8'h12, 0, 1, 13, "busy_12");
      late = 0;
      for (int c = 0; c < 50; c++) begin
         if (busy[0] !== 1'b0 || tx_w[0] !== 1'b1) late++;
         @(negedge clk);
      end
      checks++;
      if (late != 0) begin
         errors++;
         $display("FAIL no_second_frame: active cycles=%0d, want 0", late);
      end
   endtask

   task automatic test_handshake();
      logic [7:0] bytes [4] = '{8'h78, 8'h56, 8'h34, 8'h12};
      logic [7:0] got;
      int pulses = 0;
      int k;
      for (int n = 0; n < 4; n++) begin
         tx_byte  = bytes[n];
         trans[0] = 1'b1;
         for (int w = 0; w < 10 && busy[0] !== 1'b1; w++) @(negedge clk);
         checks++;
         if (busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL hs_rise %0d: busy=%b, want 1", n, busy[0]);
         end
         trans[0] = 1'b0;
         got = 8'h00;
         k = 0;
         while (busy[0] === 1'b1 && k < 100) begin
            if (k % 4 == 2 && k >= 4 && k < 36) got[k/4-1] = tx_w[0];
            k++;
            @(negedge clk);
         end
         if (done[0] === 1'b1) pulses++;
         checks++;
         if (got !== bytes[n] || k != 40) begin
            errors++;
            $display("FAIL hs_frame %0d: byte=%h len=%0d, want byte=%h len=40",
                     n, got, k, bytes[n]);
         end
      end
      checks++;
      if (pulses != 4) begin
         errors++;
         $display("FAIL hs_done_pulses: got %0d, want 4", pulses);
      end
   endtask

   task automatic test_back_to_back();
      int hi = 0;
      int lo = 0;
      tx_byte  = 8'h5A;
      trans[0] = 1'b1;
      for (int w = 0; w < 10 && busy[0] !== 1'b1; w++) @(negedge clk);
      while (busy[0] === 1'b1 && hi < 100) begin
         hi++;
         @(negedge clk);
      end
      while (busy[0] !== 1'b1 && lo < 10) begin
         lo++;
         @(negedge clk);
      end
      checks++;
      if (hi != 40 || lo != 1) begin
         errors++;
         $display("FAIL b2b_gap: high=%0d low=%0d, want high=40 low=1", hi, lo);
      end
      trans[0] = 1'b0;
      for (int w = 0; w < 100 && busy[0] === 1'b1; w++) @(negedge clk);
      checks++;
      if (busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL b2b_stop: busy=%b, want 0", busy[0]);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid_frame();
      int bad = 0;
      tx_byte  = 8'h81;
      trans[0] = 1'b1;
      @(negedge clk);
      trans[0] = 1'b0;
      repeat (17) @(negedge clk);
      checks++;
      if (tx_w[0] !== 1'b0 || busy[0] !== 1'b1) begin
         errors++;
         $display("FAIL pre_abort bit3: tx=%b busy=%b, want tx=0 busy=1", tx_w[0], busy[0]);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (tx_w[0] !== 1'b1 || busy[0] !== 1'b0 || done[0] !== 1'b0) begin
         errors++;
         $display("FAIL abort: tx=%b busy=%b done=%b, want tx=1 busy=0 done=0",
                  tx_w[0], busy[0], done[0]);
      end
      rst = 1'b1;
      for (int c = 0; c < 60; c++) begin
         if (tx_w[0] !== 1'b1 || busy[0] !== 1'b0 || done[0] !== 1'b0) bad++;
         @(negedge clk);
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL post_abort_idle: bad cycles=%0d, want 0", bad);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_parity();
      test_stop2();
      test_busy_ignored();
      test_handshake();
      test_back_to_back();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- UART transmit stage directly downstream of the packet decoder in pc_interface.
- Accepts one byte per `transmit` handshake and shifts it out on the serial TX line as an 8-bit, LSB-first frame with optional parity and 1 or 2 stop bits.
- Reports `is_transmitting` back to the decoder so it can pace multi-byte read-data uploads to the PC.

Parameters:
- CLKS_PER_BIT, 868: clk cycles per bit period (100 MHz / 115200). Legal range >= 2. Counter width is $clog2(CLKS_PER_BIT).
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-low reset (low = reset).
- transmit  input  1  byte-send request. Level-sampled only in IDLE.
- tx_byte  input  8  byte to send. Captured on the accepting edge.
- tx  output  1  serial line. Idle high.
- is_transmitting  output  1  high from the accepting edge through the end of the last stop bit.
- tx_done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (rst == 0 at a clk edge):
  - tx = 1, is_transmitting = 0, tx_done = 0.
  - State = IDLE; bit counter, baud counter and shift register cleared.
  - Reset mid-frame aborts the frame: tx returns high on that edge and nothing is retransmitted.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx = 1, is_transmitting = 0.
  - On an edge with transmit = 1: latch tx_byte into the shift register, compute the parity bit, set tx = 0, set is_transmitting = 1, clear the baud counter, go to START.
  - Latency from request to start bit is one edge.
- Bit timing:
  - Each bit holds tx for exactly CLKS_PER_BIT cycles.
  - The baud counter counts 0..CLKS_PER_BIT-1. At terminal count it resets to 0 and the next bit is driven on that same edge.
- START: at terminal count, drive data bit 0 and go to DATA.
- DATA:
  - Bits 0..7 are sent LSB first, with a 3-bit index counter.
  - After bit 7's terminal count: go to PARITY if PARITY != 0, otherwise go to STOP with tx = 1.
- Parity bit:
  - Odd: ~^data (the total count of ones, including the parity bit, is odd).
  - Even: ^data.
- PARITY: drive the parity bit for one period, then go to STOP with tx = 1.
- STOP:
  - tx = 1 for STOP_BITS*CLKS_PER_BIT cycles.
  - On the final terminal count: go to IDLE, is_transmitting = 0, tx_done = 1 for exactly that one cycle.
- Frame length: is_transmitting stays high for exactly CLKS_PER_BIT*(1+8+P+STOP_BITS) cycles, where P = (PARITY != 0).
- transmit while busy:
  - Ignored; there is no queue.
  - tx_byte changes during a frame do not affect the frame in flight.
- transmit held high continuously:
  - The frame ends, IDLE is entered, and the next edge starts a new frame.
  - is_transmitting is therefore low for exactly one cycle between frames. The decoder's wait-for-low handshake relies on this gap, so it is guaranteed.
- Registered outputs: all outputs come straight from flops; none is combinational from an input.

Test Plan:
- CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1, send 0xA5 -> tx, per 4-cycle bit slot: 0 (start), 1,0,1,0,0,1,0,1 (data), 1 (stop). is_transmitting high for 40 cycles; tx_done pulses once on the edge it falls.
- PARITY=2 (even), send 0x07 -> parity slot = 1, frame length 44 cycles. PARITY=1 (odd), send 0x07 -> parity slot = 0.
- STOP_BITS=2, send 0xFF -> tx high for 8 cycles after the last data bit before is_transmitting drops. Total 44 cycles.
- Pulse transmit with 0x3C during a frame carrying 0x12 -> 0x12 completes unaltered, and no second frame is sent.
- Decoder-style handshake: hold transmit until is_transmitting rises, drop it, wait for the fall, repeat for bytes 0x78,0x56,0x34,0x12 -> four correct frames, four tx_done pulses. Also hold transmit high across 2 frames -> is_transmitting low for exactly 1 cycle between them.
- Assert rst low during data bit 3 of a frame carrying 0x81 -> on the next edge tx=1, is_transmitting=0, tx_done=0. After release with transmit=0, tx stays high.
